// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - bus command codes (READ_WRITE_EN)
//   - register offsets within the 16-byte window
//   - STATUS / CTRL bit positions
//   - serializer FSM state encoding
// Optional feature macro: UART_TX_PARITY_EN (PARITY state, CTRL.PEN/ODD).
package mmio_uart_pkg;

  // Bus commands
  localparam logic [3:0] RW_NOP = 4'b0000;
  localparam logic [3:0] RW_LW  = 4'b0001;
  localparam logic [3:0] RW_SW  = 4'b0010;
  localparam logic [3:0] RW_SB  = 4'b0011;

  // Register offsets (ADDRESS[3:0])
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_BAUD   = 4'hC;

  // STATUS bits
  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;
  localparam int unsigned ST_OVR_BIT   = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 6;

  // CTRL bits
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_IE_BIT    = 1;
  localparam int unsigned CTRL_FLUSH_BIT = 2;
  localparam int unsigned CTRL_PEN_BIT   = 3;
  localparam int unsigned CTRL_ODD_BIT   = 4;

  // Serializer FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    enqueue request and data (dropped when full unless popping)
//   pop_i              dequeue request (ignored when empty)
//   flush_i            empties the FIFO on this edge; overrides push
//   rdata_o            head entry (combinational)
//   full_o, empty_o    occupancy flags
//   count_o            number of valid entries
module uart_tx_fifo
  import mmio_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [7:0]                   wdata_i,
  output logic [7:0]                   rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A pop on the same edge frees the slot, so a push while full is accepted.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
// Ports:
//   CLK            system clock (rising edge)
//   RESET          asynchronous active-low reset
//   READ_WRITE_EN  bus command (RW_* in mmio_uart_pkg)
//   ADDRESS        byte address; window at BASE_ADDR, 16 bytes
//   WRITEDATA      store data
//   READDATA       combinational load data (0 unless an LW hits the window)
//   SEL            ADDRESS[31:4] matches BASE_ADDR[31:4]
//   TX_OUT         serial line, idle high
//   IRQ            registered CTRL.IE & FIFO empty & FSM idle
// Optional feature macro: UART_TX_PARITY_EN adds CTRL.PEN/ODD and a parity bit.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ_WRITE_EN,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        SEL,
  output logic        TX_OUT,
  output logic        IRQ
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic        aligned, is_wr, is_rd;
  logic        wr_tx, wr_status, wr_ctrl, wr_baud;
  logic [15:0] baud_new;

  logic        en_q, ie_q, flush_q, ovr_q, irq_q, tx_q;
  logic        ovr_d, flush_d, irq_d, tx_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
`ifdef UART_TX_PARITY_EN
  logic        pen_q, odd_q;
`endif

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          unused_wd;

  assign unused_wd = ^WRITEDATA[31:16];

  // Bus decode
  assign SEL       = (ADDRESS[31:4] == BASE_ADDR[31:4]);
  assign aligned   = (ADDRESS[1:0] == 2'b00);
  assign is_wr     = SEL & aligned & ((READ_WRITE_EN == RW_SW) | (READ_WRITE_EN == RW_SB));
  assign is_rd     = SEL & aligned & (READ_WRITE_EN == RW_LW);
  assign wr_tx     = is_wr & (ADDRESS[3:0] == OFF_TXDATA);
  assign wr_status = is_wr & (ADDRESS[3:0] == OFF_STATUS);
  assign wr_ctrl   = is_wr & (ADDRESS[3:0] == OFF_CTRL);
  assign wr_baud   = is_wr & (ADDRESS[3:0] == OFF_BAUD);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (wr_tx),
    .pop_i   (fifo_pop),
    .flush_i (flush_q),
    .wdata_i (WRITEDATA[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Byte stores only touch lane 0; a zero divisor is clamped to 1.
  assign baud_new = (READ_WRITE_EN == RW_SB) ? {baud_q[15:8], WRITEDATA[7:0]} : WRITEDATA[15:0];

  always_comb begin
    baud_d = baud_q;
    if (wr_baud) baud_d = (baud_new == '0) ? 16'd1 : baud_new;
    // FLUSH is latched for one cycle and empties the FIFO on the following edge.
    flush_d = wr_ctrl & WRITEDATA[CTRL_FLUSH_BIT];
    ovr_d = ovr_q;
    if (wr_status && WRITEDATA[ST_OVR_BIT]) ovr_d = 1'b0;
    if (wr_tx && fifo_full && !fifo_pop && !flush_q) ovr_d = 1'b1;
    irq_d = ie_q & fifo_empty & (state_q == S_IDLE);
  end

  // Serializer: each bit loads cnt with DIV-1 from the current BAUD value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (en_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          state_d  = S_START;
          tx_d     = 1'b0;
          cnt_d    = baud_q - 16'd1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          cnt_d   = baud_q - 16'd1;
        end else cnt_d = cnt_q - 16'd1;
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = baud_q - 16'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (pen_q) begin
              state_d = S_PARITY;
              tx_d    = (^shreg_q) ^ odd_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[idx_q + 3'd1];
          end
        end else cnt_d = cnt_q - 16'd1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          cnt_d   = baud_q - 16'd1;
        end else cnt_d = cnt_q - 16'd1;
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          if (en_q && !fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            state_d  = S_START;
            tx_d     = 1'b0;
            cnt_d    = baud_q - 16'd1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else cnt_d = cnt_q - 16'd1;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      flush_q <= 1'b0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      tx_q    <= 1'b1;
      baud_q  <= DEFAULT_DIV;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
`ifdef UART_TX_PARITY_EN
      pen_q   <= 1'b0;
      odd_q   <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        en_q  <= WRITEDATA[CTRL_EN_BIT];
        ie_q  <= WRITEDATA[CTRL_IE_BIT];
`ifdef UART_TX_PARITY_EN
        pen_q <= WRITEDATA[CTRL_PEN_BIT];
        odd_q <= WRITEDATA[CTRL_ODD_BIT];
`endif
      end
      flush_q <= flush_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    READDATA = '0;
    if (is_rd) begin
      case (ADDRESS[3:0])
        OFF_STATUS: begin
          READDATA[ST_FULL_BIT]  = fifo_full;
          READDATA[ST_EMPTY_BIT] = fifo_empty;
          READDATA[ST_BUSY_BIT]  = (state_q != S_IDLE);
          READDATA[ST_OVR_BIT]   = ovr_q;
          READDATA[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
        end
        OFF_CTRL: begin
          READDATA[CTRL_EN_BIT] = en_q;
          READDATA[CTRL_IE_BIT] = ie_q;
`ifdef UART_TX_PARITY_EN
          READDATA[CTRL_PEN_BIT] = pen_q;
          READDATA[CTRL_ODD_BIT] = odd_q;
`endif
        end
        OFF_BAUD: READDATA[15:0] = baud_q;
        default:  READDATA = '0;
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign IRQ    = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx. A queue-based model
// tracks FIFO contents, register state and the list of line levels remaining
// in the current frame; outputs are compared against it every falling edge.
module tb_mmio_uart_tx;
  import mmio_uart_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  CMD;
  logic [31:0] ADDR, WD;
  logic [31:0] READDATA;
  logic        SEL, TX_OUT, IRQ;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ_WRITE_EN (CMD),
    .ADDRESS       (ADDR),
    .WRITEDATA     (WD),
    .READDATA      (READDATA),
    .SEL           (SEL),
    .TX_OUT        (TX_OUT),
    .IRQ           (IRQ)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_q[$];
  bit          m_lv[$];
  bit          m_en, m_ie, m_pen, m_odd, m_ovr, m_flush, m_busy, m_cur, m_irq;
  int unsigned m_rem;
  logic [15:0] m_baud;

  task automatic model_reset();
    m_q.delete(); m_lv.delete();
    m_en = 0; m_ie = 0; m_pen = 0; m_odd = 0; m_ovr = 0; m_flush = 0;
    m_busy = 0; m_cur = 1; m_irq = 0; m_rem = 0; m_baud = 16'd4;
  endtask

  task automatic start_frame();
    logic [7:0] b;
    b = m_q.pop_front();
    m_lv.delete();
    for (int i = 0; i < 8; i++) m_lv.push_back(b[i]);
    if (m_pen) m_lv.push_back((^b) ^ m_odd);
    m_lv.push_back(1'b1);
    m_cur = 0; m_rem = m_baud; m_busy = 1;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    bit irq_n, ok, fl;
    logic [15:0] nb;
    irq_n = m_ie && (m_q.size() == 0) && !m_busy;
    // line
    if (!m_busy) begin
      if (m_en && m_q.size() > 0) start_frame();
    end else if (m_rem > 1) m_rem--;
    else if (m_lv.size() > 0) begin
      m_cur = m_lv.pop_front(); m_rem = m_baud;
    end else if (m_en && m_q.size() > 0) start_frame();
    else begin
      m_busy = 0; m_cur = 1;
    end
    // bus
    ok = (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00) && (c == RW_SW || c == RW_SB);
    fl = m_flush;
    m_flush = 0;
    if (fl) m_q.delete();
    if (ok) begin
      case (a[3:0])
        4'h0: if (!fl) begin
          if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
          else m_ovr = 1;
        end
        4'h4: if (d[3]) m_ovr = 0;
        4'h8: begin
          m_en = d[0]; m_ie = d[1]; m_flush = d[2];
`ifdef UART_TX_PARITY_EN
          m_pen = d[3]; m_odd = d[4];
`endif
        end
        4'hC: begin
          nb = (c == RW_SB) ? {m_baud[15:8], d[7:0]} : d[15:0];
          m_baud = (nb == 16'd0) ? 16'd1 : nb;
        end
        default: ;
      endcase
    end
    m_irq = irq_n;
  endtask

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = 32'h0;
    if (ADDR[31:4] == BASE[31:4] && ADDR[1:0] == 2'b00 && CMD == RW_LW) begin
      case (ADDR[3:0])
        4'h4: r = {18'h0, 6'(m_q.size()), 4'h0, m_ovr, m_busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
        4'h8: r = {27'h0, m_odd, m_pen, 1'b0, m_ie, m_en};
        4'hC: r = {16'h0, m_baud};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  always @(negedge RESET) model_reset();
  always @(posedge CLK) if (RESET === 1'b1) model_step(CMD, ADDR, WD);

  always @(negedge CLK) begin
    chk("tx_out", TX_OUT, m_busy ? m_cur : 1'b1);
    chk("irq", IRQ, m_irq);
    chk("readdata", READDATA, exp_rd());
    chk("sel", SEL, ADDR[31:4] == BASE[31:4]);
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    CMD = c; ADDR = a; WD = d;
    @(posedge CLK); #1;
    CMD = RW_NOP; ADDR = 32'h0; WD = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    CMD = RW_LW; ADDR = a;
    @(negedge CLK); v = READDATA;
    @(posedge CLK); #1;
    CMD = RW_NOP; ADDR = 32'h0;
  endtask

  // Records TX_OUT for every cycle STATUS.BUSY is high; len = busy cycles.
  task automatic capture(input int maxlen, output int len, output logic [63:0] wave);
    int guard;
    guard = 0; len = 0; wave = '0;
    CMD = RW_LW; ADDR = BASE + 32'h4;
    @(negedge CLK);
    while (READDATA[2] !== 1'b1 && guard < 20) begin @(negedge CLK); guard++; end
    while (READDATA[2] === 1'b1 && len < maxlen) begin
      if (len < 64) wave[len] = TX_OUT;
      len++;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    CMD = RW_NOP; ADDR = 32'h0;
  endtask

  logic [31:0] v;
  logic [63:0] wave;
  int          len, lows, guard;
  int unsigned r;
  logic [31:0] a, d;

  initial begin
    RESET = 1'b0; CMD = RW_NOP; ADDR = 32'h0; WD = 32'h0;
    model_reset();
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    @(posedge CLK); #1;

    // reset state
    rd(BASE + 32'h4, v); chk("reset_status", v, 32'h0000_0002);
    rd(BASE + 32'hC, v); chk("reset_baud", v, 32'd4);
    chk("reset_tx", TX_OUT, 1'b1);

    // single 0xA5 frame at DIV=4
    do_op(RW_SW, BASE + 32'h8, 32'h1);
    do_op(RW_SW, BASE + 32'hC, 32'h4);
    do_op(RW_SW, BASE, 32'hA5);
    capture(100, len, wave);
    chk("a5_len", len, 40);
    chk("a5_wave", wave, 64'h00_FF0F00F0F0);
    rd(BASE + 32'h4, v); chk("a5_idle_status", v, 32'h0000_0002);

    // overflow, overrun clear, back-to-back drain
    do_op(RW_SW, BASE + 32'h8, 32'h0);
    for (int i = 0; i < 9; i++) do_op(RW_SW, BASE, 32'h30 + i);
    rd(BASE + 32'h4, v); chk("full_status", v, 32'h0000_0809);
    do_op(RW_SW, BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, v); chk("ovr_clear", v, 32'h0000_0801);
    do_op(RW_SW, BASE + 32'h8, 32'h1);
    capture(400, len, wave);
    chk("drain_len", len, 320);

    // reset mid start bit
    do_op(RW_SW, BASE, 32'h55);
    do_op(RW_SW, BASE, 32'h0F);
    guard = 0;
    @(negedge CLK);
    while (TX_OUT !== 1'b0 && guard < 20) begin @(negedge CLK); guard++; end
    chk("rst_saw_start", TX_OUT, 1'b0);
    #2 RESET = 1'b0;
    #1 chk("rst_tx", TX_OUT, 1'b1);
    CMD = RW_LW; ADDR = BASE + 32'h8;
    #1 chk("rst_ctrl", READDATA, 32'h0);
    ADDR = BASE + 32'h4;
    #1 chk("rst_status", READDATA, 32'h0000_0002);
    CMD = RW_NOP; ADDR = 32'h0;
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin @(negedge CLK); if (TX_OUT !== 1'b1) lows++; end
    chk("no_resume", lows, 0);
    @(posedge CLK); #1;

    // BAUD zero clamp, ignored commands, misaligned access
    do_op(RW_SW, BASE + 32'hC, 32'h0);
    rd(BASE + 32'hC, v); chk("baud_zero", v, 32'd1);
    do_op(RW_SW, BASE + 32'h8, 32'h1);
    do_op(RW_SW, BASE, 32'h3C);
    capture(100, len, wave);
    chk("div1_len", len, 10);
    chk("div1_wave", wave, 64'h278);
    CMD = 4'b0100; ADDR = BASE + 32'h8; WD = 32'h1F;
    @(negedge CLK); chk("lb_rd", READDATA, 32'h0);
    @(posedge CLK); #1;
    do_op(4'b0101, BASE + 32'h8, 32'h0);
    do_op(RW_SW, BASE + 32'hD, 32'h9);
    rd(BASE + 32'h8, v); chk("ignored_ctrl", v, 32'h1);
    rd(BASE + 32'hC, v); chk("ignored_baud", v, 32'd1);
    rd(BASE + 32'h2, v); chk("misaligned_rd", v, 32'h0);
    do_op(RW_SW, BASE + 32'hC, 32'h4);

`ifdef UART_TX_PARITY_EN
    do_op(RW_SW, BASE + 32'h8, 32'h19);
    do_op(RW_SW, BASE, 32'h03);
    capture(100, len, wave);
    chk("par_len", len, 44);
    chk("par_wave", wave, 64'hFF000000FF0);
    do_op(RW_SW, BASE + 32'h8, 32'h1);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      a = BASE + 32'($urandom_range(0, 3) * 4);
      d = $urandom;
      if (r < 10)      do_op(RW_NOP, a, d);
      else if (r < 30) do_op(RW_LW, a, d);
      else if (r < 60) do_op(($urandom_range(0, 1) != 0) ? RW_SW : RW_SB, BASE, d);
      else if (r < 68) do_op(RW_SW, BASE + 32'h8,
                             {29'h0, ($urandom_range(0, 15) == 0), d[1], ($urandom_range(0, 4) != 0)});
      else if (r < 73) do_op(($urandom_range(0, 1) != 0) ? RW_SW : RW_SB, BASE + 32'hC,
                             {d[31:16], 16'($urandom_range(0, 5))});
      else if (r < 78) do_op(RW_SW, BASE + 32'h4, d);
      else if (r < 85) do_op(4'($urandom_range(4, 15)), a, d);
      else if (r < 90) do_op(RW_SW, a + 32'($urandom_range(1, 3)), d);
      else if (r < 95) do_op(RW_SW, 32'h200 + (a & 32'hC), d);
      else begin repeat ($urandom_range(1, 30)) @(posedge CLK); #1; end
    end

    do_op(RW_SW, BASE + 32'h8, 32'h3);
    repeat (700) @(posedge CLK);
    #1;
    rd(BASE + 32'h4, v); chk("final_empty", v[2:0], 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter acting as a responder on the CPU data-memory bus (CLK, READ_WRITE_EN, ADDRESS, WRITEDATA, READDATA), decoded alongside data_memory.
- CPU stores bytes into a TX FIFO; a serializer FSM shifts them out on TX_OUT as 8N1 frames at a programmable baud divisor.
- Status and control registers are readable and writable by ordinary load/store instructions.

Parameters:
- BASE_ADDR, 32'h0000_0100, 16-byte-aligned base of the register window.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, range 2..32.
- DEFAULT_DIV, 16'd4, reset value of BAUD register, in CLK cycles per bit.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ_WRITE_EN  in  4  bus command; codes defined in shared package.
- ADDRESS  in  32  byte address from CPU.
- WRITEDATA  in  32  store data.
- READDATA  out  32  load data; combinational.
- SEL  out  1  high when ADDRESS[31:4]==BASE_ADDR[31:4]; the top level uses it to mux READDATA against data_memory.
- TX_OUT  out  1  serial line; idle high.
- IRQ  out  1  registered; equals CTRL.IE & FIFO empty & FSM idle.

Behaviour:
- Bus commands:
  - RW_NOP=4'b0000.
  - RW_LW=4'b0001: word read.
  - RW_SW=4'b0010: word write.
  - RW_SB=4'b0011: byte write, using WRITEDATA[7:0] to byte lane 0 only.
  - All other codes are ignored. Accesses with ADDRESS[1:0]!=0 are ignored.
- Register map (offset: use):
  - 0x0 TXDATA: write pushes WRITEDATA[7:0] into the FIFO; reads return 0.
  - 0x4 STATUS (read): bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVERRUN (sticky), bits[13:8] COUNT. Writing 1 to bit3 clears OVERRUN; other bits are read-only.
  - 0x8 CTRL (R/W): bit0 EN, bit1 IE, bit2 FLUSH (self-clearing; empties the FIFO next edge, reads 0).
  - 0xC BAUD (R/W): bits[15:0] DIV. A written value of 0 is stored as 1.
- Reads: READDATA is combinational and valid in the same cycle when SEL=1 and the command is RW_LW; otherwise 32'h0. Reads have no side effects.
- Writes take effect on the rising edge where the command is valid.
- FIFO:
  - Push when FULL: data dropped, OVERRUN set.
  - Push and pop on the same edge while full: the pop frees the slot and the push is accepted; OVERRUN is not set.
  - Pop on EMPTY never occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - FLUSH concurrent with a push: flush wins and the pushed byte is discarded.
  - FLUSH does not abort a frame in progress.
- Serializer FSM, with a 16-bit baud counter and a 3-bit bit index:
  - IDLE: TX_OUT=1. If EN & !EMPTY, pop into the shift register and go to START; TX_OUT falls on the same edge.
  - START: TX_OUT=0 for DIV cycles, then DATA.
  - DATA: shift out LSB first, 8 bits, DIV cycles each, then STOP.
  - STOP: TX_OUT=1 for DIV cycles. Then go to START directly (pop on the same edge) if EN & !EMPTY, else IDLE. Back-to-back frames have no idle gap.
- Frame timing: one frame lasts exactly 10*DIV cycles. DIV is sampled at the start of each bit; a BAUD write mid-frame affects the next bit.
- Clearing EN mid-frame completes the current frame, then the FSM stays in IDLE.
- Reset values, applied immediately when RESET goes low, even mid-frame:
  - TX_OUT=1, IRQ=0, FSM=IDLE, FIFO empty, OVERRUN=0.
  - CTRL=0, BAUD=DEFAULT_DIV.
  - READDATA is combinational, so during reset it reflects the reset register state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - CTRL bit3 PEN and bit4 ODD become R/W.
  - With PEN=1, a PARITY state is inserted between DATA and STOP, lasting DIV cycles and transmitting XOR of the data bits, inverted if ODD. The frame becomes 11*DIV cycles.
- Undefined: CTRL bits 3 and 4 read 0 and ignore writes; no PARITY state exists.

Decomposition:
- Package mmio_uart_pkg holds:
  - RW_* command codes;
  - register offsets;
  - STATUS and CTRL bit positions;
  - FSM state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/flush, full/empty/count, parameterised on FIFO_DEPTH.
- Bus decode and the FSM stay in mmio_uart_tx.

Test Plan:
- Reset then read STATUS at 0x104 -> READDATA=32'h0000_0002 (EMPTY); BAUD (0x10C) reads 4; TX_OUT=1.
- CTRL=1, BAUD=4, SW 0xA5 to 0x100 -> TX_OUT low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles; STATUS.BUSY is 1 throughout the frame.
- EN=0, push 9 bytes with FIFO_DEPTH=8 -> COUNT=8, FULL=1, OVERRUN=1. Writing 32'h8 to STATUS clears OVERRUN; setting EN drains 8 back-to-back frames totalling 320 cycles with no idle gap.
- Push 2 bytes, pulse RESET low mid start bit -> TX_OUT=1 immediately, COUNT=0, CTRL=0. No frame resumes after release.
- BAUD write of 0 -> reads back 1; a frame then lasts 10 cycles. LB/LH command codes and misaligned address 0x102 -> no state change, READDATA=0.
- With UART_TX_PARITY_EN and CTRL=32'h19 (EN, PEN, ODD), send 0x03 -> parity bit 1 after the data bits; frame lasts 11*DIV cycles.
